product_accumulator: RTL and testbench

Downstream consumer of the N-bit multiplier's 2N-bit product stream. Sums a programmable-length frame of unsigned products into a widened accumulator and presents each frame total on a valid/ready output. Frames are separated by a HOLD state, and overflow is flagged. It sits between the multiplier's p_out and the result sink, forming the MAC path of the datapath.

---
 rtl/multiplier_pkg.sv | 17 +
 rtl/product_accumulator_sat_add.sv | 27 ++
 rtl/product_accumulator.sv | 116 +++++++++++
 tb/tb_product_accumulator.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/multiplier_pkg.sv
// Shared types and sizing helpers for the multiplier / MAC datapath.
package multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

  localparam int ACC_GUARD_DEF = 8;

  // Accumulator width for an n-bit multiplier with g guard bits.
  function automatic int acc_width(input int n, input int g);
    return 2 * n + g;
  endfunction

endpackage

// File: rtl/product_accumulator_sat_add.sv
// Adds a product to the accumulator. It reports the carry out of the accumulator width.
// With ACC_SATURATE_EN defined the sum clamps to all-ones. Otherwise the sum wraps.
module sat_add #(
  parameter int W   = 24,
  parameter int B_W = 16
) (
  input  logic [W-1:0]   a,
  input  logic [B_W-1:0] b,
  output logic [W-1:0]   sum,
  output logic           carry
);

  logic [W-1:0] b_ext;
  logic [W:0]   raw;

  assign b_ext = W'(b);
  assign raw   = {1'b0, a} + {1'b0, b_ext};
  assign carry = raw[W];

`ifdef ACC_SATURATE_EN
  // Once clamped, any further non-zero add carries again, so the clamp holds for the frame.
  assign sum = carry ? {W{1'b1}} : raw[W-1:0];
`else
  assign sum = raw[W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums a frame of len unsigned products into an ACC_W-bit total and flags overflow (ACC_SATURATE_EN selects clamp vs wrap).
// Latency: the total is valid the cycle after the last product is accepted. Turnaround is len accepts + 1 HOLD cycle.
// Backpressure: p_ready is low while a total waits in HOLD for acc_ready. p_ready depends on state only.
module product_accumulator
  import multiplier_pkg::*;
#(
  parameter int  N      = 8,
  parameter int  GUARD  = ACC_GUARD_DEF,
  parameter int  LEN_W  = 8,
  localparam int ACC_W  = acc_width(N, GUARD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2*N-1:0]   p_in,
  input  logic             p_valid,
  output logic             p_ready,
  input  logic [LEN_W-1:0] len,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             ovf,
  output logic             busy
);

  acc_state_e       state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic [LEN_W-1:0] len_q, len_nxt;
  logic             ovf_q, ovf_nxt;
  logic             acc_valid_q;

  logic             accept;
  logic [LEN_W-1:0] len_eff;
  logic [LEN_W-1:0] cnt_inc;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;

  assign p_ready = (state != HOLD);
  assign accept  = p_valid && p_ready;
  assign len_eff = (len == '0) ? LEN_W'(1) : len;
  assign cnt_inc = cnt + LEN_W'(1);

  sat_add #(
    .W   (ACC_W),
    .B_W (2*N)
  ) u_sat_add (
    .a     (acc),
    .b     (p_in),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    len_nxt   = len_q;
    ovf_nxt   = ovf_q;
    if (clear) begin
      // Abort wins over any accept or drain in the same cycle.
      state_nxt = IDLE;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc_nxt   = ACC_W'(p_in);
            cnt_nxt   = LEN_W'(1);
            len_nxt   = len_eff;
            ovf_nxt   = 1'b0;
            state_nxt = (len_eff == LEN_W'(1)) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_nxt = add_sum;
            cnt_nxt = cnt_inc;
            ovf_nxt = ovf_q | add_carry;
            if (cnt_inc == len_q) state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (acc_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      acc_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      acc         <= acc_nxt;
      cnt         <= cnt_nxt;
      len_q       <= len_nxt;
      ovf_q       <= ovf_nxt;
      acc_valid_q <= (state_nxt == HOLD);
    end
  end

  assign acc_out   = acc;
  assign acc_valid = acc_valid_q;
  assign ovf       = ovf_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_product_accumulator.sv
// Drives a guarded (ACC_W=24) and an unguarded (ACC_W=16) accumulator with the same stimulus.
// Each instance is checked against a frame-level model.
module tb_product_accumulator;

  localparam int WW = 24;
  localparam int WN = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] p_in = '0;
  logic        p_valid = 1'b0;
  logic [7:0]  len = '0;
  logic        clear = 1'b0;
  logic        acc_ready = 1'b0;

  logic          p_ready_w, acc_valid_w, ovf_w, busy_w;
  logic [WW-1:0] acc_out_w;
  logic          p_ready_n, acc_valid_n, ovf_n, busy_n;
  logic [WN-1:0] acc_out_n;

  int checks = 0;
  int failures = 0;

  // Frame-level model state
  bit      in_frame = 0;
  bit      has_res  = 0;
  bit      zeroed   = 1;
  int      flen = 0;
  int      n_acc = 0;
  longint  sum = 0;
  longint  exp_w = 0, exp_n = 0;
  bit      eovf_w = 0, eovf_n = 0;

  always #5 clk = ~clk;

  product_accumulator #(.N(8), .GUARD(8), .LEN_W(8)) dut_w (
    .clk(clk), .rst_n(rst_n), .p_in(p_in), .p_valid(p_valid), .p_ready(p_ready_w),
    .len(len), .clear(clear), .acc_out(acc_out_w), .acc_valid(acc_valid_w),
    .acc_ready(acc_ready), .ovf(ovf_w), .busy(busy_w)
  );

  product_accumulator #(.N(8), .GUARD(0), .LEN_W(8)) dut_n (
    .clk(clk), .rst_n(rst_n), .p_in(p_in), .p_valid(p_valid), .p_ready(p_ready_n),
    .len(len), .clear(clear), .acc_out(acc_out_n), .acc_valid(acc_valid_n),
    .acc_ready(acc_ready), .ovf(ovf_n), .busy(busy_n)
  );

  function automatic longint fold(input longint s, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
`ifdef ACC_SATURATE_EN
    return (s > mx) ? mx : s;
`else
    return s & mx;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Advance the model across the coming clock edge using the inputs now being driven.
  task automatic model_edge();
    if (!rst_n || clear) begin
      in_frame = 0;
      has_res  = 0;
      zeroed   = 1;
    end else if (has_res) begin
      if (acc_ready) has_res = 0;
    end else if (p_valid) begin
      if (!in_frame) begin
        in_frame = 1;
        flen     = (len == 0) ? 1 : int'(len);
        n_acc    = 0;
        sum      = 0;
        zeroed   = 0;
      end
      sum += longint'(p_in);
      n_acc++;
      if (n_acc == flen) begin
        in_frame = 0;
        has_res  = 1;
        exp_w  = fold(sum, WW);
        exp_n  = fold(sum, WN);
        eovf_w = (sum >= (longint'(1) << WW));
        eovf_n = (sum >= (longint'(1) << WN));
      end
    end
  endtask

  task automatic compare_all();
    check("p_ready_w", 64'(p_ready_w), 64'(!has_res));
    check("p_ready_n", 64'(p_ready_n), 64'(!has_res));
    check("acc_valid_w", 64'(acc_valid_w), 64'(has_res));
    check("acc_valid_n", 64'(acc_valid_n), 64'(has_res));
    check("busy_w", 64'(busy_w), 64'(in_frame || has_res));
    check("busy_n", 64'(busy_n), 64'(in_frame || has_res));
    if (has_res) begin
      check("acc_out_w", 64'(acc_out_w), 64'(exp_w));
      check("acc_out_n", 64'(acc_out_n), 64'(exp_n));
      check("ovf_w", 64'(ovf_w), 64'(eovf_w));
      check("ovf_n", 64'(ovf_n), 64'(eovf_n));
    end else if (zeroed) begin
      check("zero_acc_w", 64'(acc_out_w), 64'd0);
      check("zero_acc_n", 64'(acc_out_n), 64'd0);
      check("zero_ovf_w", 64'(ovf_w), 64'd0);
      check("zero_ovf_n", 64'(ovf_n), 64'd0);
    end
  endtask

  task automatic step(input bit r, input bit c, input bit pv, input logic [15:0] p,
                      input logic [7:0] l, input bit ar);
    rst_n     = !r;
    clear     = c;
    p_valid   = pv;
    p_in      = p;
    len       = l;
    acc_ready = ar;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("rst_valid", 64'(acc_valid_w), 64'd0);
    check("rst_ready", 64'(p_ready_w), 64'd1);
    check("rst_busy", 64'(busy_w), 64'd0);
    check("rst_acc", 64'(acc_out_w), 64'd0);

    // len=4, back-to-back products
    step(0, 0, 1, 16'd6, 8'd4, 1);
    step(0, 0, 1, 16'd12, 8'd4, 1);
    step(0, 0, 1, 16'd20, 8'd4, 1);
    step(0, 0, 1, 16'd30, 8'd4, 1);
    check("t1_model", 64'(exp_w), 64'd68);
    check("t1_sum", 64'(acc_out_w), 64'd68);
    check("t1_valid", 64'(acc_valid_w), 64'd1);
    check("t1_ovf", 64'(ovf_w), 64'd0);
    step(0, 0, 0, 16'd0, 8'd4, 1);
    check("t1_busy_after", 64'(busy_w), 64'd0);

    // len=3, 255*255 three times with 2-cycle gaps
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 16'd65025, 8'd3, 1);
      if (i < 2) begin
        step(0, 0, 0, 16'd0, 8'd3, 1);
        check("t2_gap_ready", 64'(p_ready_w), 64'd1);
        step(0, 0, 0, 16'd0, 8'd3, 1);
      end
    end
    check("t2_sum", 64'(acc_out_w), 64'd195075);
    step(0, 0, 0, 16'd0, 8'd3, 1);

    // Stall in HOLD for 5 cycles while p_valid is asserted
    step(0, 0, 1, 16'd7, 8'd1, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 16'd99, 8'd1, 0);
      check("t3_stable", 64'(acc_out_w), 64'd7);
      check("t3_ready_low", 64'(p_ready_w), 64'd0);
    end
    step(0, 0, 1, 16'd99, 8'd1, 1);
    check("t3_idle_ready", 64'(p_ready_w), 64'd1);
    step(0, 0, 1, 16'd5, 8'd1, 0);
    check("t3_next", 64'(acc_out_w), 64'd5);
    step(0, 0, 0, 16'd0, 8'd1, 1);

    // Carry out of the unguarded instance
    step(0, 0, 1, 16'hFF01, 8'd2, 1);
    step(0, 0, 1, 16'hFF01, 8'd2, 1);
`ifdef ACC_SATURATE_EN
    check("t4_sum_n", 64'(acc_out_n), 64'hFFFF);
`else
    check("t4_sum_n", 64'(acc_out_n), 64'hFE02);
`endif
    check("t4_ovf_n", 64'(ovf_n), 64'd1);
    check("t4_sum_w", 64'(acc_out_w), 64'h1FE02);
    check("t4_ovf_w", 64'(ovf_w), 64'd0);
    step(0, 0, 0, 16'd0, 8'd2, 1);

    // clear mid-frame, then a single-product frame
    step(0, 0, 1, 16'd3, 8'd4, 1);
    step(0, 0, 1, 16'd4, 8'd4, 1);
    step(0, 1, 1, 16'd50, 8'd4, 1);
    check("t5_busy", 64'(busy_w), 64'd0);
    check("t5_acc", 64'(acc_out_w), 64'd0);
    step(0, 0, 1, 16'd9, 8'd1, 0);
    check("t5_sum", 64'(acc_out_w), 64'd9);
    check("t5_ovf", 64'(ovf_w), 64'd0);

    // Reset while holding a result
    step(1, 0, 0, 16'd0, 8'd1, 0);
    check("t6_valid", 64'(acc_valid_w), 64'd0);
    check("t6_acc", 64'(acc_out_w), 64'd0);
    check("t6_busy", 64'(busy_w), 64'd0);
    check("t6_ready", 64'(p_ready_w), 64'd1);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      logic [15:0] p;
      logic [7:0]  l;
      p = 16'($urandom);
      if ($urandom_range(0, 3) == 0) p = p | 16'hF000;
      l = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 3) != 0, p, l, $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
